// File: rtl/net_out_arbiter_if.sv
// Transmit bundle for net_out_arbiter: N_PORTS requester flit streams in,
// one merged 64-bit flit stream out.
interface net_out_arbiter_if #(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0]    in_valid;
  logic [N_PORTS-1:0]    in_ready;
  logic [64*N_PORTS-1:0] in_data;
  logic [8*N_PORTS-1:0]  in_keep;
  logic [N_PORTS-1:0]    in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [63:0]           out_data;
  logic [7:0]            out_keep;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, in_keep, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_keep, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/net_out_arbiter.sv
// Packet-granular round-robin arbiter sharing one network transmit stream
// among N_PORTS requesters, with per-port packet counters and oversize flags.
module net_out_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int MAX_FLITS = 190
) (
  input  logic                   clock,
  input  logic                   reset,
  net_out_arbiter_if.slave       bus,
  output logic [2:0]             grant_port,
  output logic                   busy,
  output logic [16*N_PORTS-1:0]  pkt_count,
  output logic [N_PORTS-1:0]     oversize
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_FLITS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       grant_reg, grant_next;
  logic [2:0]       last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] flit_cnt_reg, flit_cnt_next;

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic [2:0]       arb_port;
  logic             arb_found;
  logic             xfer;
  logic             at_limit;

  assign sel        = grant_reg[IDX_W-1:0];
  assign grant_port = grant_reg;
  assign busy       = (state_reg == BUSY);
  assign xfer       = bus.out_valid && bus.out_ready;
  assign at_limit   = (flit_cnt_reg == CNT_W'(MAX_FLITS));

  // Rotating priority: the search starts just after the last port served.
  always_comb begin
    arb_found = 1'b0;
    arb_port  = '0;
    cand      = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = IDX_W'((int'(last_grant_reg) + k) % N_PORTS);
      if (!arb_found && bus.in_valid[cand]) begin
        arb_found = 1'b1;
        arb_port  = 3'(cand);
      end
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_keep  = '0;
    bus.out_last  = 1'b0;
    if (state_reg == BUSY) begin
      bus.out_valid = bus.in_valid[sel];
      bus.out_data  = bus.in_data[64*sel +: 64];
      bus.out_keep  = bus.in_keep[8*sel +: 8];
      bus.out_last  = bus.in_last[sel];
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    flit_cnt_next   = flit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          grant_next = arb_port;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (bus.out_last) begin
            last_grant_next = grant_reg;
            flit_cnt_next   = '0;
            state_next      = IDLE;
          end else if (!at_limit) begin
            flit_cnt_next = flit_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= 3'(N_PORTS - 1);
      flit_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      flit_cnt_reg   <= flit_cnt_next;
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic        granted;
    logic [15:0] pkt_cnt_reg;
    logic        oversize_reg;

    assign granted         = (state_reg == BUSY) && (sel == IDX_W'(gi));
    assign bus.in_ready[gi] = granted && bus.out_ready;

    // A flit moving while the count already sits at the limit means the packet is too long.
    always_ff @(posedge clock) begin
      if (reset) begin
        pkt_cnt_reg  <= '0;
        oversize_reg <= 1'b0;
      end else begin
        if (granted && xfer && bus.out_last) pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        if (granted && xfer && at_limit)     oversize_reg <= 1'b1;
      end
    end

    assign pkt_count[16*gi +: 16] = pkt_cnt_reg;
    assign oversize[gi]           = oversize_reg;
  end
endmodule

// File: tb/tb_net_out_arbiter.sv
// Scoreboard bench for net_out_arbiter: per-port flit drivers, expected
// transfer order queued by hand, monitor pops and compares each transfer.
module tb_net_out_arbiter;
  localparam int NP = 4;
  localparam int MF = 190;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } flit_t;

  typedef struct packed {
    logic [2:0] port;
    flit_t      f;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           grant_port;
  logic                 busy;
  logic [16*NP-1:0]     pkt_count;
  logic [NP-1:0]        oversize;

  int   checks    = 0;
  int   errors    = 0;
  int   mon_count = 0;
  int   cyc       = 0;
  logic gap_on    = 1'b0;
  exp_t exp_q[$];

  net_out_arbiter_if #(.N_PORTS(NP)) bus();

  net_out_arbiter #(.N_PORTS(NP), .MAX_FLITS(MF)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .grant_port (grant_port),
    .busy       (busy),
    .pkt_count  (pkt_count),
    .oversize   (oversize)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NP; gi++) begin : g_drv
    flit_t q[$];
    flit_t cur  = '0;
    logic  vld  = 1'b0;
    logic  fire = 1'b0;

    always @(negedge clock) fire = !reset && bus.in_valid[gi] && bus.in_ready[gi];

    always @(posedge clock) begin
      #1;
      if (fire && q.size() > 0) void'(q.pop_front());
      if (q.size() > 0) begin
        vld = 1'b1;
        cur = q[0];
      end else begin
        vld = 1'b0;
        cur = '0;
      end
    end

    assign bus.in_valid[gi]        = vld;
    assign bus.in_data[64*gi +: 64] = cur.data;
    assign bus.in_keep[8*gi +: 8]   = cur.keep;
    assign bus.in_last[gi]          = cur.last;
  end

  function automatic flit_t mk(int port, int pkt, int idx, int n);
    flit_t f;
    f.data = {8'(port), 8'(pkt), 16'hA5C3, 32'(idx)};
    f.last = (idx == n - 1);
    f.keep = f.last ? 8'h3F : 8'hFF;
    return f;
  endfunction

  task automatic src_pkt(int port, int pkt, int n);
    for (int i = 0; i < n; i++) begin
      case (port)
        0: g_drv[0].q.push_back(mk(port, pkt, i, n));
        1: g_drv[1].q.push_back(mk(port, pkt, i, n));
        2: g_drv[2].q.push_back(mk(port, pkt, i, n));
        default: g_drv[3].q.push_back(mk(port, pkt, i, n));
      endcase
    end
  endtask

  task automatic exp_pkt(int port, int pkt, int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.port = 3'(port);
      e.f    = mk(port, pkt, i, n);
      exp_q.push_back(e);
    end
  endtask

  function automatic int src_pending();
    return g_drv[0].q.size() + g_drv[1].q.size() + g_drv[2].q.size() + g_drv[3].q.size();
  endfunction

  task automatic src_clear();
    g_drv[0].q.delete();
    g_drv[1].q.delete();
    g_drv[2].q.delete();
    g_drv[3].q.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check_eq(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || src_pending() != 0) begin
      errors++;
      $display("FAIL %s drain got=%0d_left want=0_left", name, exp_q.size());
    end
  endtask

  task automatic wait_count(int target, int budget);
    int n = 0;
    while (mon_count < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Monitor: every accepted output flit must be the next one the scoreboard expects.
  logic have_prev = 1'b0;
  int   prev_cyc  = 0;
  always @(negedge clock) begin
    exp_t got;
    exp_t e;
    if (!gap_on) have_prev = 1'b0;
    if (!reset && bus.out_valid && bus.out_ready) begin
      got.port   = grant_port;
      got.f.data = bus.out_data;
      got.f.keep = bus.out_keep;
      got.f.last = bus.out_last;
      $display("xfer %0d cyc=%0d port=%0d data=%h keep=%h last=%b",
               mon_count, cyc, got.port, got.f.data, got.f.keep, got.f.last);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer got=%h want=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL xfer got=%h want=%h", got, e);
        end
      end
      if (gap_on) begin
        if (have_prev) begin
          checks++;
          if (cyc - prev_cyc != 2) begin
            errors++;
            $display("FAIL pkt_gap got=%0d want=2", cyc - prev_cyc);
          end
        end
        have_prev = 1'b1;
        prev_cyc  = cyc;
      end
      mon_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    logic pushed1;
    flit_t held;

    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_grant", 64'(grant_port), 64'd0);
    check_eq("rst_out_data", bus.out_data, 64'd0);
    check_eq("rst_pkt_count", pkt_count, 64'd0);
    check_eq("rst_oversize", 64'(oversize), 64'd0);
    reset = 1'b0;
    tick();

    // All four ports request at once; port 0 has a second packet queued.
    gap_on = 1'b1;
    src_pkt(3, 13, 1);
    src_pkt(2, 12, 1);
    src_pkt(1, 11, 1);
    src_pkt(0, 10, 1);
    src_pkt(0, 14, 1);
    exp_pkt(0, 10, 1);
    exp_pkt(1, 11, 1);
    exp_pkt(2, 12, 1);
    exp_pkt(3, 13, 1);
    exp_pkt(0, 14, 1);
    wait_drain("rr_all", 40);
    gap_on = 1'b0;
    check_eq("t1_pkt_count", pkt_count, {16'd1, 16'd1, 16'd1, 16'd2});

    // Port 1 shows up mid-packet and must wait for port 2's last flit.
    base    = mon_count;
    pushed1 = 1'b0;
    src_pkt(2, 20, 3);
    exp_pkt(2, 20, 3);
    exp_pkt(1, 21, 1);
    for (int n = 0; n < 40 && mon_count < base + 4; n++) begin
      tick();
      if (!pushed1 && mon_count >= base + 1) begin
        src_pkt(1, 21, 1);
        pushed1 = 1'b1;
      end else if (pushed1 && mon_count < base + 3) begin
        check_eq("t2_in_ready1", 64'(bus.in_ready[1]), 64'd0);
        check_eq("t2_grant", 64'(grant_port), 64'd2);
      end
    end
    wait_drain("hold_grant", 40);
    check_eq("t2_pkt_count", pkt_count, {16'd1, 16'd2, 16'd2, 16'd2});

    // Backpressure on the third flit of a 4-flit packet.
    base = mon_count;
    src_pkt(0, 30, 4);
    exp_pkt(0, 30, 4);
    wait_count(base + 2, 40);
    bus.out_ready = 1'b0;
    held = mk(0, 30, 2, 4);
    repeat (5) begin
      tick();
      check_eq("t3_stall_valid", 64'(bus.out_valid), 64'd1);
      check_eq("t3_stall_data", bus.out_data, held.data);
    end
    check_eq("t3_stall_count", 64'(mon_count), 64'(base + 2));
    bus.out_ready = 1'b1;
    wait_drain("backpressure", 40);
    check_eq("t3_pkt_count", pkt_count, {16'd1, 16'd2, 16'd2, 16'd3});

    // Exactly MAX_FLITS is legal; one more flit sets the sticky flag.
    src_pkt(2, 40, MF);
    exp_pkt(2, 40, MF);
    wait_drain("max_len", 500);
    check_eq("t4_oversize_190", 64'(oversize), 64'd0);
    src_pkt(3, 41, MF + 1);
    exp_pkt(3, 41, MF + 1);
    wait_drain("over_len", 500);
    check_eq("t4_oversize_191", 64'(oversize), 64'h8);
    src_pkt(3, 42, 1);
    exp_pkt(3, 42, 1);
    wait_drain("after_over", 40);
    check_eq("t4_oversize_sticky", 64'(oversize), 64'h8);
    check_eq("t4_pkt_count", pkt_count, {16'd3, 16'd3, 16'd2, 16'd3});

    // Reset while port 1 is on flit 2 of 4.
    base = mon_count;
    src_pkt(1, 50, 4);
    exp_pkt(1, 50, 4);
    wait_count(base + 1, 40);
    reset = 1'b1;
    exp_q.delete();
    src_clear();
    tick();
    check_eq("t5_busy", 64'(busy), 64'd0);
    check_eq("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("t5_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("t5_grant", 64'(grant_port), 64'd0);
    check_eq("t5_pkt_count", pkt_count, 64'd0);
    check_eq("t5_oversize", 64'(oversize), 64'd0);
    reset = 1'b0;
    src_pkt(3, 51, 1);
    src_pkt(2, 52, 1);
    exp_pkt(2, 52, 1);
    exp_pkt(3, 51, 1);
    wait_drain("post_reset", 40);
    check_eq("t5_pkt_after", pkt_count, {16'd1, 16'd1, 16'd0, 16'd0});

    // Lone requester: back-to-back packets with one arbitration cycle between.
    gap_on = 1'b1;
    for (int p = 0; p < 4; p++) begin
      src_pkt(1, 60 + p, 1);
      exp_pkt(1, 60 + p, 1);
    end
    wait_drain("lone", 40);
    gap_on = 1'b0;
    check_eq("t6_pkt_count", pkt_count, {16'd1, 16'd1, 16'd4, 16'd0});
    tick();
    check_eq("t6_idle_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
